// File: rtl/imem_loader.sv
// imem_loader
//    Boot-time program loader for the single-cycle MIPS core's byte-wide,
//    big-endian instruction memory.
//
//    A length-prefixed byte stream arrives over a valid/ready handshake.
//    It consists of LEN_HI and LEN_LO (a 16-bit word count N), followed by
//    4*N data bytes. Byte k of the data is written to instruction-memory
//    address k. The core is held in reset for the whole load and is released
//    one edge after the final byte has been written.
//
// Ports
//    clk        rising-edge clock
//    rst        asynchronous, active-low reset
//    start      single-cycle pulse that begins or restarts a load
//    rx_valid   stream byte valid
//    rx_data    stream byte
//    rx_ready   loader can accept a byte (decoded from state only)
//    mem_we     instruction-memory byte write enable (registered)
//    mem_addr   instruction-memory byte address (registered)
//    mem_wdata  byte to write (registered)
//    core_rst   active-high reset to the core's PC; 1 holds the core
//    done       load complete, core running
//    err        requested length does not fit in the memory
module imem_loader #(
   parameter int MEM_BYTES = 256,
   parameter int ADDR_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [7:0]        rx_data,
   output logic              rx_ready,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [7:0]        mem_wdata,
   output logic              core_rst,
   output logic              done,
   output logic              err
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_DONE,
      S_ERR
   } state_t;

   localparam logic [17:0]     MEM_BYTES_W = 18'(MEM_BYTES);
   localparam logic [ADDR_W:0] CNT_ONE     = (ADDR_W+1)'(1);

   state_t            state;
   state_t            state_nxt;
   logic [15:0]       len;
   logic [ADDR_W:0]   counter;
   logic              xfer;
   logic [15:0]       len_new;
   logic [17:0]       bytes_new;
   logic [17:0]       last_idx;

   assign rx_ready  = (state == S_LEN_HI) || (state == S_LEN_LO) || (state == S_DATA);
   assign xfer      = rx_valid && rx_ready;

   // The length check is done at 18 bits so that 4*N cannot overflow.
   assign len_new   = {len[15:8], rx_data};
   assign bytes_new = {len_new, 2'b00};
   assign last_idx  = {len, 2'b00} - 18'd1;

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic. start only has an effect in IDLE, DONE and ERR.
   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (start) state_nxt = S_LEN_HI;
         S_LEN_HI: if (xfer)  state_nxt = S_LEN_LO;
         S_LEN_LO: begin
            if (xfer) begin
               if (len_new == 16'd0) begin
                  state_nxt = S_DONE;
               end else if (bytes_new > MEM_BYTES_W) begin
                  state_nxt = S_ERR;
               end else begin
                  state_nxt = S_DATA;
               end
            end
         end
         S_DATA:   if (xfer && (18'(counter) == last_idx)) state_nxt = S_DONE;
         S_DONE:   if (start) state_nxt = S_LEN_HI;
         S_ERR:    if (start) state_nxt = S_LEN_HI;
         default:  state_nxt = S_IDLE;
      endcase
   end

   // Datapath and registered outputs. A byte accepted in DATA is presented
   // on mem_* for exactly the following cycle. core_rst/done lag entry into
   // DONE by one edge, so the final write always lands before the core runs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         len       <= '0;
         counter   <= '0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         core_rst  <= 1'b1;
         done      <= 1'b0;
         err       <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         if ((state == S_LEN_HI) && xfer) begin
            len[15:8] <= rx_data;
         end
         if ((state == S_LEN_LO) && xfer) begin
            len[7:0] <= rx_data;
            counter  <= '0;
         end
         if ((state == S_DATA) && xfer) begin
            mem_we    <= 1'b1;
            mem_addr  <= counter[ADDR_W-1:0];
            mem_wdata <= rx_data;
            counter   <= counter + CNT_ONE;
         end
         core_rst <= !((state == S_DONE) && !start);
         done     <= (state == S_DONE) && !start;
         err      <= (state_nxt == S_ERR);
      end
   end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader for the single-cycle MIPS core's byte-wide, big-endian instruction memory. It accepts a length-prefixed byte stream over a valid/ready handshake and writes each byte to consecutive instruction-memory addresses. While loading, it holds the core in reset. Once the final byte has been written, it releases the core so execution starts from PC 0.

## Interface
Parameters:
- MEM_BYTES, 256: instruction-memory capacity in bytes.
- ADDR_W, 8: byte-address width; 2^ADDR_W ≥ MEM_BYTES.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  reset, asynchronous and active-low.
- start  in  1  single-cycle pulse that begins or restarts a load.
- rx_valid  in  1  stream byte valid.
- rx_data  in  8  stream byte.
- rx_ready  out  1  loader can accept a byte.
- mem_we  out  1  instruction-memory byte write enable.
- mem_addr  out  ADDR_W  byte address.
- mem_wdata  out  8  byte to write.
- core_rst  out  1  active-high reset to the core's PC. 1 means the core is held.
- done  out  1  load complete; core running.
- err  out  1  length rejected.

## Operation
Stream format:
- LEN_HI byte, then LEN_LO byte: 16-bit word count N, big-endian.
- Then 4·N data bytes, MSB first per word. Byte k is written to address k.
- A transfer occurs on any rising edge where rx_valid && rx_ready.

States:
- **IDLE**
  - rx_ready=0, core_rst=1.
  - start → LEN_HI.
- **LEN_HI**
  - rx_ready=1.
  - On transfer: len[15:8] ← rx_data → LEN_LO.
- **LEN_LO**
  - rx_ready=1.
  - On transfer: len[7:0] ← rx_data, then:
    - N == 0 → DONE.
    - 4·N > MEM_BYTES, evaluated at ≥18-bit width → ERR.
    - Otherwise → DATA with byte counter = 0.
- **DATA**
  - rx_ready=1.
  - On each transfer: register mem_we=1, mem_addr=counter[ADDR_W-1:0], mem_wdata=rx_data for exactly the next cycle; then increment counter.
  - Transfer of byte 4·N−1 → DONE.
- **DONE**
  - rx_ready=0.
  - core_rst and done are registered and update one edge after entering DONE: core_rst=0, done=1.
  - start → LEN_HI; on that same edge core_rst=1 and done=0.
- **ERR**
  - rx_ready=0, err=1, core_rst=1, no writes.
  - start → LEN_HI; err=0 on that same edge.

Rules:
- start is ignored in LEN_HI, LEN_LO and DATA.
- mem_we is 0 in every cycle that does not follow a DATA transfer.
- rx_data is ignored when no transfer occurs.
- Asserting rst at any time, including mid-DATA, immediately forces the reset values below. Already-written memory bytes are left as they are. The next load restarts at address 0.

## Timing
- Reset values: state IDLE, rx_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, core_rst=1, done=0, err=0, counter=0, len=0.
- rx_ready is decoded combinationally from the state register and has no combinational path from rx_valid.
- Write latency: a byte accepted at edge E is presented on mem_* during cycle E..E+1 and written by the memory at E+1.
- Last byte accepted at edge E0:
  - state=DONE and mem_we=1 (last byte) after E0.
  - core_rst=0, done=1 and mem_we=0 after E0+1.
  - The core therefore never leaves reset before the final write.
- N=0: core_rst falls one edge after the LEN_LO transfer edge.
- Throughput: one byte per cycle when rx_valid is held high. Gaps in rx_valid stall the loader without any loss of state.
- Counter width: ADDR_W+1 bits minimum. The length check guarantees the address never wraps.

## Test plan
- Reset: drive rst=0 mid-cycle → all outputs take reset values asynchronously, before the next edge.
- Load with MEM_BYTES=256: start, then bytes 00 02 20 08 00 05 AC 01 00 04 back-to-back → eight single-cycle writes at addr 0..7 with data 20,08,00,05,AC,01,00,04. Two edges after the last transfer, core_rst=0 and done=1. rx_ready=0 afterwards.
- Backpressure: same stream with rx_valid low every other cycle and junk on rx_data during the gaps → identical writes and addresses; exactly 8 mem_we pulses.
- Zero length: start, bytes 00 00 → no mem_we; done=1 and core_rst=0 two edges after the LEN_LO transfer.
- Oversize: start, bytes 00 41 (N=65, 260 bytes > 256) → err=1, core_rst=1, rx_ready=0, no writes. Then start, 00 01, four bytes → err clears and the load completes normally at addr 0..3.
- Reset mid-load: N=2, reset asserted after 3 data bytes → outputs return to reset values. Then start plus a full N=1 stream → writes begin again at addr 0. A start pulse sent during DATA is ignored.
